inst_fetch_resp: RTL and testbench
==================================

Name: inst_fetch_resp

Overview:
Instruction-memory responder that serves the fetch requests issued by the PC register.
- Samples the word address and fetch enable every cycle.
- Returns the addressed 32-bit instruction with one cycle of latency.
- Includes a program-load write port, out-of-range fault detection and a fetch counter for bring-up and debug.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
DEPTH, 1024, number of 32-bit instruction words; power of two
AW, 10, log2(DEPTH); index width into the array
ADDR_W, 32, width of the incoming fetch address (word address)
NOP_INST, 32'h00000013, instruction returned on idle, fault or load

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  reset; asynchronous, active-high
ce_i  input  1  fetch enable from PC register; 1 = request a fetch this cycle
addr_i  input  ADDR_W  word address of the instruction to fetch
ld_en_i  input  1  program-load write strobe
ld_addr_i  input  AW  word index to write
ld_data_i  input  32  instruction word to write
inst_o  output  32  fetched instruction
inst_valid_o  output  1  inst_o carries a response to a request from the previous cycle
fault_o  output  1  current response was out of range (addr_i >= DEPTH)
fault_sticky_o  output  1  set by any fault; cleared only by reset
busy_o  output  1  responder is in LOAD; fetches are being refused
fetch_cnt_o  output  32  count of successful (non-fault) fetch responses

Behaviour:
- Reset (rst_i=1, asynchronous): all outputs and state are forced immediately.
  - inst_o=NOP_INST, inst_valid_o=0, fault_o=0, fault_sticky_o=0, busy_o=0, fetch_cnt_o=0.
  - FSM goes to IDLE.
  - Memory array contents are NOT reset.
  - A reset asserted mid-load or mid-fetch aborts it; a write at the same edge as reset assertion is not guaranteed.
- FSM states: IDLE, SERVE, LOAD. Transitions are evaluated at each rising edge, priority top-down:
  - ld_en_i=1 -> LOAD. Also writes mem[ld_addr_i]=ld_data_i at that edge.
  - ce_i=1 -> SERVE.
  - otherwise -> IDLE.
- busy_o: registered; equals 1 exactly when state==LOAD.
- LOAD cycle (edge with ld_en_i=1):
  - inst_o=NOP_INST, inst_valid_o=0, fault_o=0.
  - The fetch request is dropped, not queued, even if ce_i=1.
  - fetch_cnt_o unchanged.
- SERVE cycle (edge with ld_en_i=0, ce_i=1). The response is visible after that edge (1-cycle latency):
  - If addr_i < DEPTH (all bits above AW-1 zero): inst_o=mem[addr_i[AW-1:0]], inst_valid_o=1, fault_o=0. fetch_cnt_o increments, saturating at 32'hFFFFFFFF.
  - If addr_i >= DEPTH: inst_o=NOP_INST, inst_valid_o=1, fault_o=1, fault_sticky_o set. fetch_cnt_o unchanged.
- IDLE cycle (ld_en_i=0, ce_i=0):
  - inst_valid_o=0, fault_o=0.
  - inst_o holds its last value.
- Back-to-back fetches: one response per cycle with no bubbles; consecutive addresses need not be sequential.
- Load then fetch of the same index:
  - A write at edge N is readable by a fetch sampled at edge N+1; response at N+1 returns the new data.
  - Read and write at the same edge cannot occur because load has priority.
- Address aliasing is forbidden: out-of-range addresses always fault, never wrap into the array.
- Memory: single synchronous write port and synchronous read port, inferable as block RAM. No reset on the array.

Test Plan:
1. Reset release, then ce_i=1, addr_i=0,1,2 on consecutive cycles, with mem preloaded 0x00100093, 0x00200113, 0x00308193.
   -> inst_o shows those words one cycle after each request; inst_valid_o=1 for 3 cycles; fetch_cnt_o=3.
2. ld_en_i=1 for 4 cycles writing index 5..8 with 0xA0000000+i, while ce_i=1 and addr_i=0.
   -> busy_o=1 for 4 cycles; inst_valid_o=0; inst_o=0x00000013; fetch_cnt_o unchanged.
   Then fetch addr 5..8 -> 0xA0000005..0xA0000008.
3. Fetch addr_i=DEPTH (1024), then addr_i=32'hFFFFFFFF.
   -> both responses: inst_o=0x00000013, inst_valid_o=1, fault_o=1, fault_sticky_o=1.
   Following in-range fetch -> fault_o=0, fault_sticky_o stays 1.
4. Load index 3 with 0xDEADBEEF at edge N, fetch addr 3 at edge N+1.
   -> inst_o=0xDEADBEEF after N+1.
5. ce_i toggling 1,0,1 with addr 0,1,2.
   -> inst_valid_o=1,0,1; inst_o holds word 0 during the idle cycle.
6. Assert rst_i asynchronously mid-stream with fetch_cnt_o=7 and fault_sticky_o=1.
   -> outputs reset immediately without a clock edge; mem contents intact on the next fetch.

Source files
------------

// File: rtl/inst_fetch_resp_if.sv
// Fetch request/response and program-load bus between the PC register,
// the instruction memory responder and the IF/ID pipeline register.
interface inst_fetch_resp_if #(
    parameter int AW     = 10,
    parameter int ADDR_W = 32
);
    // Handshake: ce_i is a one-cycle request with no back-pressure. Every
    // request sampled at edge N gets exactly one response with inst_valid_o=1
    // after edge N unless ld_en_i was also high at N (the request is dropped).
    logic              ce_i;
    logic [ADDR_W-1:0] addr_i;
    logic              ld_en_i;
    logic [AW-1:0]     ld_addr_i;
    logic [31:0]       ld_data_i;
    logic [31:0]       inst_o;
    logic              inst_valid_o;
    logic              fault_o;
    logic              fault_sticky_o;
    logic              busy_o;
    logic [31:0]       fetch_cnt_o;

    modport master (
        output ce_i, addr_i, ld_en_i, ld_addr_i, ld_data_i,
        input  inst_o, inst_valid_o, fault_o, fault_sticky_o, busy_o, fetch_cnt_o
    );

    modport slave (
        input  ce_i, addr_i, ld_en_i, ld_addr_i, ld_data_i,
        output inst_o, inst_valid_o, fault_o, fault_sticky_o, busy_o, fetch_cnt_o
    );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction memory responder: one-cycle-latency fetch, program-load port,
// out-of-range fault detection and a saturating fetch counter.
module inst_fetch_resp #(
    parameter int          DEPTH    = 1024,
    parameter int          AW       = 10,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    inst_fetch_resp_if.slave     bus,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        fault_q, fault_d;
    logic        sticky_q, sticky_d;
    logic        use_mem_q, use_mem_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rd_en;
    logic        in_range;
    logic [31:0] rd_data_q;
    logic [31:0] mem [DEPTH];

    // Any set bit above the index field faults; addresses never wrap.
    assign in_range = ((bus.addr_i >> AW) == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            fault_q   <= 1'b0;
            sticky_q  <= 1'b0;
            use_mem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            sticky_q  <= sticky_d;
            use_mem_q <= use_mem_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = IDLE;
        fault_d   = 1'b0;
        sticky_d  = sticky_q;
        use_mem_d = use_mem_q;
        cnt_d     = cnt_q;
        rd_en     = 1'b0;
        if (bus.ld_en_i) begin
            state_d   = LOAD;
            use_mem_d = 1'b0;
        end else if (bus.ce_i) begin
            state_d = SERVE;
            if (in_range) begin
                rd_en     = 1'b1;
                use_mem_d = 1'b1;
                if (cnt_q != 32'hFFFF_FFFF)
                    cnt_d = cnt_q + 32'd1;
            end else begin
                fault_d   = 1'b1;
                sticky_d  = 1'b1;
                use_mem_d = 1'b0;
            end
        end
    end

    // Array and read register carry no reset so they map onto block RAM;
    // use_mem_q substitutes NOP_INST whenever the read data is not a response.
    always_ff @(posedge clk_i) begin
        if (bus.ld_en_i)
            mem[bus.ld_addr_i] <= bus.ld_data_i;
        if (rd_en)
            rd_data_q <= mem[bus.addr_i[AW-1:0]];
    end

    assign bus.inst_o         = use_mem_q ? rd_data_q : NOP_INST;
    assign bus.inst_valid_o   = (state_q == SERVE);
    assign bus.fault_o        = fault_q;
    assign bus.fault_sticky_o = sticky_q;
    assign bus.busy_o         = (state_q == LOAD);
    assign bus.fetch_cnt_o    = cnt_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed, table-driven bench for inst_fetch_resp plus hand-written
// asynchronous reset sequences.
module tb_inst_fetch_resp;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic        ld_en;
        logic [9:0]  ld_addr;
        logic [31:0] ld_data;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_fault;
        logic        e_sticky;
        logic        e_busy;
        logic [31:0] e_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         failures = 0;
    vec_t       vq[$];

    inst_fetch_resp_if #(.AW(10), .ADDR_W(32)) bus ();

    inst_fetch_resp #(
        .DEPTH(1024), .AW(10), .ADDR_W(32), .NOP_INST(NOP)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .state_o(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] inst, input logic valid,
                           input logic fault, input logic sticky, input logic busy,
                           input logic [31:0] cnt);
        chk({tag, " inst"},   bus.inst_o, inst);
        chk({tag, " valid"},  {31'd0, bus.inst_valid_o}, {31'd0, valid});
        chk({tag, " fault"},  {31'd0, bus.fault_o}, {31'd0, fault});
        chk({tag, " sticky"}, {31'd0, bus.fault_sticky_o}, {31'd0, sticky});
        chk({tag, " busy"},   {31'd0, bus.busy_o}, {31'd0, busy});
        chk({tag, " cnt"},    bus.fetch_cnt_o, cnt);
    endtask

    // driver tasks
    task automatic drive(input logic ld_en, input logic [9:0] ld_addr, input logic [31:0] ld_data,
                         input logic ce, input logic [31:0] addr);
        bus.ld_en_i   = ld_en;
        bus.ld_addr_i = ld_addr;
        bus.ld_data_i = ld_data;
        bus.ce_i      = ce;
        bus.addr_i    = addr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ld_en, input logic [9:0] ld_addr, input logic [31:0] ld_data,
                       input logic ce, input logic [31:0] addr, input logic [31:0] e_inst,
                       input logic e_valid, input logic e_fault, input logic e_sticky,
                       input logic e_busy, input logic [31:0] e_cnt);
        vec_t v;
        v.ld_en = ld_en; v.ld_addr = ld_addr; v.ld_data = ld_data;
        v.ce = ce; v.addr = addr; v.e_inst = e_inst; v.e_valid = e_valid;
        v.e_fault = e_fault; v.e_sticky = e_sticky; v.e_busy = e_busy; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    initial begin
        drive(1'b0, 10'd0, 32'd0, 1'b0, 32'd0);

        // preload words 0..2
        add(1, 10'd0, 32'h00100093, 0, 32'd0, NOP, 0, 0, 0, 1, 32'd0);
        add(1, 10'd1, 32'h00200113, 0, 32'd0, NOP, 0, 0, 0, 1, 32'd0);
        add(1, 10'd2, 32'h00308193, 0, 32'd0, NOP, 0, 0, 0, 1, 32'd0);
        // back-to-back fetches
        add(0, 10'd0, 32'd0, 1, 32'd0, 32'h00100093, 1, 0, 0, 0, 32'd1);
        add(0, 10'd0, 32'd0, 1, 32'd1, 32'h00200113, 1, 0, 0, 0, 32'd2);
        add(0, 10'd0, 32'd0, 1, 32'd2, 32'h00308193, 1, 0, 0, 0, 32'd3);
        // load has priority over a concurrent fetch, which is dropped
        for (int i = 5; i <= 8; i++)
            add(1, 10'(i), 32'hA0000000 + 32'(i), 1, 32'd0, NOP, 0, 0, 0, 1, 32'd3);
        for (int i = 5; i <= 8; i++)
            add(0, 10'd0, 32'd0, 1, 32'(i), 32'hA0000000 + 32'(i), 1, 0, 0, 0, 32'(i - 1));
        // out-of-range: 1024 would alias to word 0 if bits were dropped
        add(0, 10'd0, 32'd0, 1, 32'd1024,       NOP, 1, 1, 1, 0, 32'd7);
        add(0, 10'd0, 32'd0, 1, 32'hFFFFFFFF,   NOP, 1, 1, 1, 0, 32'd7);
        add(0, 10'd0, 32'd0, 1, 32'd1029,       NOP, 1, 1, 1, 0, 32'd7);
        add(0, 10'd0, 32'd0, 1, 32'd0, 32'h00100093, 1, 0, 1, 0, 32'd8);
        // write at N, read at N+1
        add(1, 10'd3, 32'hDEADBEEF, 0, 32'd0, NOP, 0, 0, 1, 1, 32'd8);
        add(0, 10'd0, 32'd0, 1, 32'd3, 32'hDEADBEEF, 1, 0, 1, 0, 32'd9);
        // ce toggling: idle cycle holds the last word
        add(0, 10'd0, 32'd0, 1, 32'd0, 32'h00100093, 1, 0, 1, 0, 32'd10);
        add(0, 10'd0, 32'd0, 0, 32'd1, 32'h00100093, 0, 0, 1, 0, 32'd10);
        add(0, 10'd0, 32'd0, 1, 32'd2, 32'h00308193, 1, 0, 1, 0, 32'd11);
        // idle after a load keeps NOP
        add(1, 10'd9, 32'h12345678, 0, 32'd0, NOP, 0, 0, 1, 1, 32'd11);
        add(0, 10'd0, 32'd0, 0, 32'd0, NOP, 0, 0, 1, 0, 32'd11);

        // power-on reset, asserted between edges
        #1 rst = 1'b1;
        #2;
        chk_all("reset", NOP, 0, 0, 0, 0, 32'd0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].ld_en, vq[i].ld_addr, vq[i].ld_data, vq[i].ce, vq[i].addr);
            step();
            chk_all($sformatf("v%0d", i), vq[i].e_inst, vq[i].e_valid, vq[i].e_fault,
                    vq[i].e_sticky, vq[i].e_busy, vq[i].e_cnt);
        end

        // mid-stream async reset: build up a response, then reset between edges
        drive(0, 10'd0, 32'd0, 1, 32'd6);
        step();
        chk_all("pre_rst", 32'hA0000006, 1, 0, 1, 0, 32'd12);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", NOP, 0, 0, 0, 0, 32'd0);
        chk("async_rst state", {30'd0, state_dbg}, 32'd0);
        // edges while reset is held must not advance anything
        step();
        chk_all("rst_held", NOP, 0, 0, 0, 0, 32'd0);
        rst = 1'b0;
        // array contents survive reset
        drive(0, 10'd0, 32'd0, 1, 32'd5);
        step();
        chk_all("post_rst5", 32'hA0000005, 1, 0, 0, 0, 32'd1);
        drive(0, 10'd0, 32'd0, 1, 32'd3);
        step();
        chk_all("post_rst3", 32'hDEADBEEF, 1, 0, 0, 0, 32'd2);

        // reset asserted during a load aborts it
        drive(1, 10'd10, 32'h55555555, 0, 32'd0);
        step();
        chk_all("load_busy", NOP, 0, 0, 0, 1, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk_all("load_rst", NOP, 0, 0, 0, 0, 32'd0);
        step();
        rst = 1'b0;
        drive(0, 10'd0, 32'd0, 0, 32'd0);
        step();
        chk_all("after_load_rst", NOP, 0, 0, 0, 0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
